pal_macrocell_fabric: RTL and testbench
=======================================

Name: pal_macrocell_fabric

Overview:
- Next-generation parametrised PAL: programmable AND plane, programmable OR plane, and one macrocell per output.
- Macrocells select registered or combinational output, with optional inversion; registered outputs feed back into the AND plane.
- Configuration is loaded through a double-buffered serial chain with bit counting, length checking, commit and daisy-chain output.
- Sits behind the chip-top wrapper; configuration arrives on dedicated IO pins.

Parameters:
- N, 8, number of external inputs.
- M, 4, number of outputs / macrocells.
- P, 16, number of product terms.
- Derived localparams:
  - L = N+M, literal sources.
  - AND_BITS = P*2*L.
  - OR_BITS = M*P.
  - MC_BITS = 2*M.
  - OE_BITS = M*2*L when PAL_OE_EN is defined, else 0.
  - CFG_BITS = sum of the above.

Ports:
- clk  in  1  single clock; fabric registers and config chain.
- res  in  1  synchronous reset, active-high.
- cfg_en  in  1  shift enable; high = shift one bit per clk.
- cfg_in  in  1  serial config data; first bit shifted in ends at index CFG_BITS-1.
- cfg_out  out  1  shadow register bit CFG_BITS-1 before the shift (daisy chain / readback).
- cfg_done  out  1  one-cycle pulse on successful commit.
- cfg_err  out  1  sticky length-error flag; cleared by res or the next successful commit.
- cfg_valid  out  1  active configuration present.
- in_vars  in  N  input variables.
- out_vals  out  M  macrocell outputs.
- out_oe  out  M  per-output enable.

Behaviour:

Reset (res high at a clk edge):
- All state cleared: shadow, active config, macrocell FFs, counter, flags; FSM goes to UNCFG.
- Resulting outputs: out_vals=0, out_oe=0, cfg_out=0, cfg_done=0, cfg_err=0, cfg_valid=0.
- Reset mid-shift discards the partial load.

Config bit layout (shadow/active index, LSB up):
- AND plane: term p, literal k: index p*2L+2k is the true literal, +1 is the complement.
  - Literal k<N is in_vars[k]; literal k>=N is macrocell FF q[k-N].
- OR plane: bit AND_BITS + m*P + p connects term p to output m.
- Macrocell m: bit AND_BITS+OR_BITS+2m is reg_mode; +1 is invert.
- OE terms (PAL_OE_EN only) follow, same literal encoding as the AND plane.

FSM states UNCFG, SHIFT, ACTIVE:
- UNCFG or ACTIVE, with cfg_en=1:
  - Go to SHIFT; this cycle shifts the first bit; counter=1.
- SHIFT, cfg_en=1:
  - Shadow <= {shadow[CFG_BITS-2:0], cfg_in}.
  - Counter increments and saturates at CFG_BITS+1.
- SHIFT, cfg_en=0, counter==CFG_BITS:
  - Active config <= shadow; macrocell FFs cleared; cfg_valid=1; cfg_err=0.
  - cfg_done pulses the following cycle; next state is ACTIVE.
- SHIFT, cfg_en=0, counter!=CFG_BITS:
  - No commit; cfg_err=1.
  - Return to ACTIVE if cfg_valid, else UNCFG.
- During SHIFT the fabric keeps running on the old active config (double buffered).

Fabric:
- Product term = AND of its enabled literals. A term with no enabled literal evaluates 0.
- Selecting both polarities of one literal gives 0.
- OR output = OR of its connected terms; no connected terms gives 0.
- d_m = OR_m XOR invert_m.
- Macrocell FF q_m <= d_m every clk while cfg_valid.
- out_vals[m] = reg_mode_m ? q_m : d_m; forced 0 while !cfg_valid.
- Feedback always uses q_m, never d_m, so there are no combinational loops.
- Combinational path in_vars -> out_vals has zero latency; registered path has 1 cycle.

Optional Feature:
- Macro: PAL_OE_EN.
- Defined:
  - Each output gets one extra OE product term; out_oe[m] = that term AND cfg_valid.
  - OE_BITS is added to CFG_BITS.
- Undefined:
  - out_oe = {M{cfg_valid}}.
  - OE_BITS=0; no OE storage is generated.

Decomposition:
- Package pal_pkg holds:
  - State enum pal_state_t (UNCFG, SHIFT, ACTIVE).
  - Functions computing CFG_BITS and the field offsets from N, M, P.
- One sub-module pal_product_term: literal vector plus enable mask -> term output; instantiated P times, plus M more under PAL_OE_EN.

Test Plan:
All scenarios use N=2, M=1, P=2, PAL_OE_EN undefined, so CFG_BITS=16.
1. Reset: res high, then low -> out_vals=0, cfg_valid=0, cfg_err=0, out_oe=0.
2. AND gate:
   - Shift 16'h1005 MSB first (term0 = in0 & in1, OR bit 12, combinational), then drop cfg_en.
   - cfg_done pulses once; cfg_valid=1.
   - in_vars=2'b11 -> out_vals=1 in the same cycle; 2'b01 -> 0.
3. Registered toggle:
   - Config term0 = ~fb (bit 5), OR bit 12, reg_mode bit 14: word 16'h5020.
   - out_vals alternates 0,1,0,1 on consecutive clks after commit.
4. Length error:
   - With config 2 active, shift 15 bits -> cfg_err=1, no cfg_done.
   - Toggling continues unchanged.
   - A later full 16-bit load clears cfg_err.
5. Daisy chain: shift 32 bits of which the first 16 are 16'hA5C3 -> cfg_out reproduces 16'hA5C3 during bits 17-32.
6. Reset mid-shift: assert res after 8 bits -> UNCFG; the next 16-bit load commits normally.

Source files
------------

// File: rtl/pal_pkg.sv
// Shared types and configuration-layout helpers for the PAL macrocell fabric.
// Optional output-enable product terms are compiled in with PAL_OE_EN.
package pal_pkg;

  typedef enum logic [1:0] {
    StUncfg  = 2'd0,
    StShift  = 2'd1,
    StActive = 2'd2
  } pal_state_t;

  // AND plane: P terms, each with a true/complement bit per literal source
  function automatic int unsigned and_bits(int unsigned n, int unsigned m, int unsigned p);
    return p * 2 * (n + m);
  endfunction

  function automatic int unsigned or_bits(int unsigned m, int unsigned p);
    return m * p;
  endfunction

  function automatic int unsigned mc_bits(int unsigned m);
    return 2 * m;
  endfunction

  // Offset of the OR plane within the configuration word
  function automatic int unsigned or_off(int unsigned n, int unsigned m, int unsigned p);
    return and_bits(n, m, p);
  endfunction

  // Offset of the macrocell {invert, reg_mode} pairs
  function automatic int unsigned mc_off(int unsigned n, int unsigned m, int unsigned p);
    return and_bits(n, m, p) + or_bits(m, p);
  endfunction

`ifdef PAL_OE_EN
  // OE terms sit directly above the macrocell bits
  function automatic int unsigned oe_off(int unsigned n, int unsigned m, int unsigned p);
    return mc_off(n, m, p) + mc_bits(m);
  endfunction
`endif

  function automatic int unsigned cfg_bits(int unsigned n, int unsigned m, int unsigned p);
`ifdef PAL_OE_EN
    return mc_off(n, m, p) + mc_bits(m) + m * 2 * (n + m);
`else
    return mc_off(n, m, p) + mc_bits(m);
`endif
  endfunction

endpackage

// File: rtl/pal_macrocell_fabric_if.sv
// Configuration chain and fabric IO bundle for the PAL macrocell fabric.
interface pal_macrocell_fabric_if #(
  parameter int unsigned N = 8,
  parameter int unsigned M = 4
);
  logic         cfg_en;
  logic         cfg_in;
  logic         cfg_out;
  logic         cfg_done;
  logic         cfg_err;
  logic         cfg_valid;
  logic [N-1:0] in_vars;
  logic [M-1:0] out_vals;
  logic [M-1:0] out_oe;

  modport master (
    output cfg_en, cfg_in, in_vars,
    input  cfg_out, cfg_done, cfg_err, cfg_valid, out_vals, out_oe
  );

  modport slave (
    input  cfg_en, cfg_in, in_vars,
    output cfg_out, cfg_done, cfg_err, cfg_valid, out_vals, out_oe
  );
endinterface

// File: rtl/pal_product_term.sv
// One programmable product term: AND of the literals selected by the mask.
// An empty mask yields 0 rather than the vacuous-AND value of 1.
module pal_product_term #(
  parameter int unsigned W = 2
) (
  input  logic [W-1:0] lits_i,
  input  logic [W-1:0] mask_i,
  output logic         term_o
);
  assign term_o = (|mask_i) & (&(lits_i | ~mask_i));
endmodule

// File: rtl/pal_macrocell_fabric.sv
// Parametrised PAL: AND plane, OR plane and one macrocell per output, loaded
// through a double-buffered serial chain. PAL_OE_EN adds one OE product term
// per output; without it every output is enabled whenever config is valid.
module pal_macrocell_fabric
  import pal_pkg::*;
#(
  parameter int unsigned N = 8,
  parameter int unsigned M = 4,
  parameter int unsigned P = 16
) (
  input logic                   clk,
  input logic                   res,
  pal_macrocell_fabric_if.slave bus
);
  localparam int unsigned L       = N + M;
  localparam int unsigned W       = 2 * L;
  localparam int unsigned CfgBits = cfg_bits(N, M, P);
  localparam int unsigned OrOff   = or_off(N, M, P);
  localparam int unsigned McOff   = mc_off(N, M, P);
  localparam int unsigned CntW    = $clog2(CfgBits + 2);
  localparam logic [CntW-1:0] CntFull = CntW'(CfgBits);
  localparam logic [CntW-1:0] CntSat  = CntW'(CfgBits + 1);

  pal_state_t         state_q, state_d;
  logic [CfgBits-1:0] shadow_q, shadow_d;
  logic [CfgBits-1:0] cfg_q, cfg_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic               valid_q, valid_d;
  logic               err_q, err_d;
  logic               done_q, done_d;
  logic               commit;
  logic [M-1:0]       q_q, q_d;
  logic [M-1:0]       d;
  logic [M-1:0]       out_vals;
  logic [L-1:0]       src;
  logic [W-1:0]       lits;
  logic [P-1:0]       term;

  // Feedback comes only from the macrocell FFs, so the planes stay loop-free
  assign src = {q_q, bus.in_vars};

  // Expand each literal source into its true/complement pair
  always_comb begin
    lits = '0;
    for (int k = 0; k < int'(L); k++) begin
      lits[2*k]   = src[k];
      lits[2*k+1] = ~src[k];
    end
  end

  for (genvar p = 0; p < P; p++) begin : g_term
    pal_product_term #(
      .W(W)
    ) u_term (
      .lits_i (lits),
      .mask_i (cfg_q[p*W +: W]),
      .term_o (term[p])
    );
  end

  // OR plane, inversion and output select per macrocell
  always_comb begin
    d        = '0;
    out_vals = '0;
    for (int m = 0; m < int'(M); m++) begin
      d[m]        = (|(term & cfg_q[OrOff + m*P +: P])) ^ cfg_q[McOff + 2*m + 1];
      out_vals[m] = valid_q & (cfg_q[McOff + 2*m] ? q_q[m] : d[m]);
    end
  end

  // Commit clears the macrocells so the new config starts from a known state
  always_comb begin
    q_d = q_q;
    if (commit) begin
      q_d = '0;
    end else if (valid_q) begin
      q_d = d;
    end
  end

  // Config loader FSM: shift, length check, commit
  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    cnt_d    = cnt_q;
    cfg_d    = cfg_q;
    valid_d  = valid_q;
    err_d    = err_q;
    done_d   = 1'b0;
    commit   = 1'b0;
    case (state_q)
      StUncfg, StActive: begin
        if (bus.cfg_en) begin
          state_d  = StShift;
          shadow_d = {shadow_q[CfgBits-2:0], bus.cfg_in};
          cnt_d    = CntW'(1);
        end
      end
      StShift: begin
        if (bus.cfg_en) begin
          shadow_d = {shadow_q[CfgBits-2:0], bus.cfg_in};
          if (cnt_q != CntSat) begin
            cnt_d = cnt_q + CntW'(1);
          end
        end else if (cnt_q == CntFull) begin
          cfg_d   = shadow_q;
          valid_d = 1'b1;
          err_d   = 1'b0;
          done_d  = 1'b1;
          commit  = 1'b1;
          state_d = StActive;
        end else begin
          err_d   = 1'b1;
          state_d = valid_q ? StActive : StUncfg;
        end
      end
      default: state_d = StUncfg;
    endcase
  end

  // All state registers with synchronous reset
  always_ff @(posedge clk) begin
    if (res) begin
      state_q  <= StUncfg;
      shadow_q <= '0;
      cfg_q    <= '0;
      cnt_q    <= '0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
      done_q   <= 1'b0;
      q_q      <= '0;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      cfg_q    <= cfg_d;
      cnt_q    <= cnt_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
      done_q   <= done_d;
      q_q      <= q_d;
    end
  end

`ifdef PAL_OE_EN
  localparam int unsigned OeOff = oe_off(N, M, P);
  logic [M-1:0] oe_term;

  for (genvar m = 0; m < M; m++) begin : g_oe
    pal_product_term #(
      .W(W)
    ) u_oe (
      .lits_i (lits),
      .mask_i (cfg_q[OeOff + m*W +: W]),
      .term_o (oe_term[m])
    );
  end

  assign bus.out_oe = oe_term & {M{valid_q}};
`else
  assign bus.out_oe = {M{valid_q}};
`endif

  assign bus.out_vals  = out_vals;
  assign bus.cfg_out   = shadow_q[CfgBits-1];
  assign bus.cfg_done  = done_q;
  assign bus.cfg_err   = err_q;
  assign bus.cfg_valid = valid_q;

endmodule

// File: tb/tb_pal_macrocell_fabric.sv
// Directed bench for pal_macrocell_fabric with N=2, M=1, P=2 (16 config bits).
module tb_pal_macrocell_fabric;

  typedef struct {
    logic [1:0] in_vars;
    logic       exp_out;
  } vec_t;

  logic clk = 1'b0;
  logic res = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;

  pal_macrocell_fabric_if #(.N(2), .M(1)) bus ();

  pal_macrocell_fabric #(
    .N(2),
    .M(1),
    .P(2)
  ) dut (
    .clk (clk),
    .res (res),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Shift the top nbits of w, MSB first, leaving cfg_en low afterwards
  task automatic shift_bits(input logic [15:0] w, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      bus.cfg_en = 1'b1;
      bus.cfg_in = w[15-i];
      tick();
    end
    bus.cfg_en = 1'b0;
    bus.cfg_in = 1'b0;
  endtask

  // Full load; returns just after the commit edge
  task automatic load_word(input logic [15:0] w);
    shift_bits(w, 16);
    #1;
    chk("done_before_commit", 32'(bus.cfg_done), 32'd0);
    tick();
  endtask

  vec_t and_tab[4];
  logic [15:0] daisy;
  logic exp_q;

  initial begin
    and_tab[0] = '{2'b00, 1'b0};
    and_tab[1] = '{2'b01, 1'b0};
    and_tab[2] = '{2'b10, 1'b0};
    and_tab[3] = '{2'b11, 1'b1};
    daisy = 16'hA5C3;

    bus.cfg_en  = 1'b0;
    bus.cfg_in  = 1'b0;
    bus.in_vars = 2'b11;

    // 1. reset
    tick();
    tick();
    res = 1'b0;
    #1;
    chk("rst_out_vals", 32'(bus.out_vals), 32'd0);
    chk("rst_valid", 32'(bus.cfg_valid), 32'd0);
    chk("rst_err", 32'(bus.cfg_err), 32'd0);
    chk("rst_oe", 32'(bus.out_oe), 32'd0);
    chk("rst_done", 32'(bus.cfg_done), 32'd0);
    chk("rst_cfg_out", 32'(bus.cfg_out), 32'd0);

    // 2. AND gate, combinational
    load_word(16'h1005);
    chk("and_done", 32'(bus.cfg_done), 32'd1);
    chk("and_valid", 32'(bus.cfg_valid), 32'd1);
    chk("and_oe", 32'(bus.out_oe), 32'd1);
    for (int i = 0; i < 4; i++) begin
      bus.in_vars = and_tab[i].in_vars;
      #1;
      chk($sformatf("and_vec%0d", i), 32'(bus.out_vals), 32'(and_tab[i].exp_out));
    end
    tick();
    chk("and_done_pulse_end", 32'(bus.cfg_done), 32'd0);

    // 3. registered toggle
    load_word(16'h5020);
    chk("tog_done", 32'(bus.cfg_done), 32'd1);
    exp_q = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("tog_cyc%0d", i), 32'(bus.out_vals), 32'(exp_q));
      tick();
      exp_q = ~exp_q;
    end

    // 4. length error: 15 bits while toggling continues
    for (int i = 0; i < 15; i++) begin
      bus.cfg_en = 1'b1;
      bus.cfg_in = 1'b0;
      #1;
      chk($sformatf("short_tog%0d", i), 32'(bus.out_vals), 32'(exp_q));
      tick();
      exp_q = ~exp_q;
    end
    bus.cfg_en = 1'b0;
    tick();
    exp_q = ~exp_q;
    chk("short_err", 32'(bus.cfg_err), 32'd1);
    chk("short_no_done", 32'(bus.cfg_done), 32'd0);
    chk("short_valid", 32'(bus.cfg_valid), 32'd1);
    chk("short_tog_after", 32'(bus.out_vals), 32'(exp_q));
    tick();
    exp_q = ~exp_q;
    chk("short_err_sticky", 32'(bus.cfg_err), 32'd1);
    chk("short_tog_after2", 32'(bus.out_vals), 32'(exp_q));
    load_word(16'h5020);
    chk("reload_err_clr", 32'(bus.cfg_err), 32'd0);
    chk("reload_done", 32'(bus.cfg_done), 32'd1);
    chk("reload_q_clr", 32'(bus.out_vals), 32'd0);

    // 5. daisy chain: cfg_out replays the first 16 bits during bits 17..32
    shift_bits(daisy, 16);
    for (int j = 0; j < 16; j++) begin
      bus.cfg_en = 1'b1;
      bus.cfg_in = 1'b0;
      #1;
      chk($sformatf("daisy_bit%0d", j), 32'(bus.cfg_out), 32'(daisy[15-j]));
      tick();
    end
    bus.cfg_en = 1'b0;
    tick();
    chk("daisy_len_err", 32'(bus.cfg_err), 32'd1);

    // 6. reset mid-shift discards the partial load
    shift_bits(16'h1005, 8);
    res = 1'b1;
    tick();
    res = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(bus.cfg_valid), 32'd0);
    chk("mid_rst_err", 32'(bus.cfg_err), 32'd0);
    chk("mid_rst_out", 32'(bus.out_vals), 32'd0);
    chk("mid_rst_cfg_out", 32'(bus.cfg_out), 32'd0);
    load_word(16'h1005);
    chk("mid_rst_done", 32'(bus.cfg_done), 32'd1);
    chk("mid_rst_valid2", 32'(bus.cfg_valid), 32'd1);
    bus.in_vars = 2'b11;
    #1;
    chk("mid_rst_and11", 32'(bus.out_vals), 32'd1);
    bus.in_vars = 2'b10;
    #1;
    chk("mid_rst_and10", 32'(bus.out_vals), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
